// File: rtl/led_key_ctrl.sv
// Key-to-LED controller: synchronises and debounces raw keys, then drives LED
// groups in direct, toggle, blink or chase mode with optional mirror and invert.
module led_key_ctrl #(
    parameter int N_KEY          = 4,
    parameter int LEDS_PER_KEY   = 2,
    parameter int DEB_CYCLES     = 240000,
    parameter int TICK_DIV       = 6000000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_KEY-1:0]              key,
    input  logic [3:0]                    sw,
    output logic [N_KEY*LEDS_PER_KEY-1:0] led,
    output logic [N_KEY-1:0]              key_pressed
);

    localparam int N_LED  = N_KEY * LEDS_PER_KEY;
    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int PTR_W  = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [N_KEY-1:0] KEY_IDLE = KEY_ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_CHASE  = 2'b11
    } mode_e;

    logic [N_KEY-1:0]  r_key_s1, r_key_s2;
    logic [3:0]        r_sw_s1, r_sw_s2;
    logic [N_KEY-1:0]  r_stable;
    logic [DEB_W-1:0]  r_deb_cnt [N_KEY];
    logic [N_KEY-1:0]  r_active_q;
    logic [N_KEY-1:0]  r_key_pressed;
    logic [N_KEY-1:0]  r_tog;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_phase;
    logic [PTR_W-1:0]  r_ptr;
    logic [N_LED-1:0]  r_led;

    logic [N_KEY-1:0]  w_active;
    logic              w_tick;
    mode_e             w_mode;
    logic [N_LED-1:0]  w_pattern;
    logic [N_LED-1:0]  w_mirror;
    logic [N_LED-1:0]  w_shaped;

    assign w_active = r_stable ^ KEY_IDLE;
    assign w_tick   = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_mode   = mode_e'(r_sw_s2[1:0]);

    // NOTE: every register below uses <= so all of them sample pre-edge values,
    // which is what makes the pipeline latencies line up with the edge counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_s1 <= KEY_IDLE;
            r_key_s2 <= KEY_IDLE;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // A key flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stable <= KEY_IDLE;
            for (int i = 0; i < N_KEY; i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_KEY; i++) begin
                if (r_key_s2[i] != r_stable[i]) begin
                    if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        r_stable[i]  <= r_key_s2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active_q    <= '0;
            r_key_pressed <= '0;
            r_tog         <= '0;
        end else begin
            r_active_q    <= w_active;
            r_key_pressed <= w_active & ~r_active_q;
            r_tog         <= r_tog ^ r_key_pressed;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_phase    <= 1'b0;
            r_ptr      <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
            if (w_tick) begin
                r_phase <= ~r_phase;
                // A held key swallows the tick, freezing the chase position.
                if (w_active == '0) begin
                    r_ptr <= (r_ptr == PTR_W'(N_LED - 1)) ? '0 : r_ptr + PTR_W'(1);
                end
            end
        end
    end

    // NOTE: defaults first so no path through the case leaves a bit unassigned.
    always_comb begin
        w_pattern = '0;
        case (w_mode)
            MODE_DIRECT: for (int i = 0; i < N_KEY; i++)
                w_pattern[i*LEDS_PER_KEY +: LEDS_PER_KEY] = {LEDS_PER_KEY{w_active[i]}};
            MODE_TOGGLE: for (int i = 0; i < N_KEY; i++)
                w_pattern[i*LEDS_PER_KEY +: LEDS_PER_KEY] = {LEDS_PER_KEY{r_tog[i]}};
            MODE_BLINK:  for (int i = 0; i < N_KEY; i++)
                w_pattern[i*LEDS_PER_KEY +: LEDS_PER_KEY] = {LEDS_PER_KEY{r_tog[i] & r_phase}};
            MODE_CHASE:  for (int j = 0; j < N_LED; j++)
                w_pattern[j] = (r_ptr == PTR_W'(j));
            default:     w_pattern = '0;
        endcase
    end

    always_comb begin
        w_mirror = '0;
        for (int j = 0; j < N_LED; j++) w_mirror[j] = w_pattern[N_LED-1-j];
    end

    assign w_shaped = (r_sw_s2[2] ? w_mirror : w_pattern) ^ {N_LED{r_sw_s2[3]}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_shaped;
        end
    end

    assign led         = r_led;
    assign key_pressed = r_key_pressed;

endmodule
